// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - iterative radix-4 Booth multiplier; optional early termination under BOOTH_EARLY_TERM_EN

module booth_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int N_STEPS = (WIDTH + 2) / 2;
  localparam int CW      = $clog2(N_STEPS);
  localparam int AW      = 2 * WIDTH + 2;
  localparam int MW      = WIDTH + 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT         state;
  stateT         nextState;
  logic [AW-1:0] mcand;
  logic [AW-1:0] acc;
  logic [AW-1:0] addend;
  logic [AW-1:0] accSum;
  logic [MW-1:0] mplier;
  logic [MW-1:0] mplierNext;
  logic [CW-1:0] count;
  logic          lastStep;
  logic          signA;
  logic          signB;

  // Unsigned operands are zero-extended so they look positive to the signed Booth datapath
  assign signA = is_signed & A[WIDTH-1];
  assign signB = is_signed & B[WIDTH-1];

  // Booth digit decode of the current multiplier triplet into a partial product
  always_comb begin
    addend = '0;
    case (mplier[2:0])
      3'b001, 3'b010: addend = mcand;
      3'b011:         addend = mcand << 1;
      3'b100:         addend = -(mcand << 1);
      3'b101, 3'b110: addend = -mcand;
      default:        addend = '0;
    endcase
    accSum     = acc + addend;
    mplierNext = {{2{mplier[MW-1]}}, mplier[MW-1:2]};
  end

`ifdef BOOTH_EARLY_TERM_EN
  // Stop as soon as the bits still to be scanned are pure sign extension (all later digits are 0)
  assign lastStep = (count == CW'(N_STEPS - 1)) || (mplierNext == '0) || (&mplierNext);
`else
  assign lastStep = (count == CW'(N_STEPS - 1));
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) nextState = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (lastStep) nextState = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath: operand capture, one Booth digit per RUN cycle, result capture on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{(WIDTH + 2){signA}}, A};
            mplier <= {{2{signB}}, B, 1'b0};
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          acc    <= accSum;
          mcand  <= mcand << 2;
          mplier <= mplierNext;
          count  <= count + CW'(1);
          if (lastStep) result <= accSum[2*WIDTH-1:0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule
